stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
- Control FSM that sequences one chronometer instance for a user-facing stopwatch.
- Takes two raw button levels (start/stop, lap/reset) and detects their rising edges.
- Drives the chronometer's reset and count-enable inputs, captures lap values, and selects the value to show (live or frozen lap).
- Sits between the button-input logic and the display driver; the chronometer count feeds back into it.

Parameters:
- SIZE_RECORD_TIMER, 9, width of the chronometer count and of all time outputs.
- LIMIT_RECORD_TIMER, 511, count value at which overflow is declared; must be ≤ 2^SIZE_RECORD_TIMER − 1.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btnStartStop  input  1  start/stop button level, already synchronised to clk.
- btnLapReset  input  1  lap/clear button level, already synchronised to clk.
- recordTimer  input  SIZE_RECORD_TIMER  live count from the chronometer.
- resetChronometer  output  1  to the chronometer's synchronous clear.
- enableTimmerCounter  output  1  to the chronometer's count enable.
- displayValue  output  SIZE_RECORD_TIMER  value for the display.
- lapActive  output  1  high while displayValue is frozen.
- running  output  1  high while the chronometer is counting.
- overflow  output  1  sticky overflow flag.

Behaviour:
- Reset: asynchronous, active-high; while asserted the block is held in this state.
  - state = IDLE; button history registers = 0; lapTime = 0; overflow = 0.
  - Resulting outputs: resetChronometer = 1, enableTimmerCounter = 0, running = 0, lapActive = 0, displayValue = recordTimer.
- Edge detect: each button has a 1-bit previous-value register.
  - edge = level & ~prev, so exactly one edge per press, however long the button is held.
  - prev updates every cycle, in all states.
- Simultaneous edges in the same cycle: the start/stop edge wins and the lap/reset edge is discarded.
- States: IDLE, RUNNING, LAP, PAUSED (2-bit encoded).
- Transitions (evaluated at the posedge where the edge is seen; the new state is visible immediately after that edge):
  - IDLE: startStop → RUNNING; lapReset ignored.
  - RUNNING: startStop → PAUSED; lapReset → LAP and lapTime ← recordTimer, sampled at that same posedge.
  - LAP: startStop → PAUSED (lap freeze released); lapReset → RUNNING (freeze released, live count shown).
  - PAUSED: startStop → RUNNING; lapReset → IDLE (clears the chronometer and clears overflow).
- Outputs are a Moore decode of the state register:
  - resetChronometer = (state == IDLE).
  - enableTimmerCounter = running = (state == RUNNING || state == LAP).
  - lapActive = (state == LAP).
  - displayValue = lapActive ? lapTime : recordTimer (combinational mux).
- Latency:
  - Button edge to enable change: 1 clk.
  - The chronometer's own internal delay before its count moves is outside this block.
- Count behaviour:
  - The chronometer keeps counting during LAP; only the displayed value is frozen.
  - In PAUSED the count holds and displayValue shows it.
- Reset mid-operation: asynchronous return to IDLE from any state; a captured lap value is lost.

Optional Feature:
- Macro: STOPWATCH_OVERFLOW_STOP_EN.
- With the macro defined:
  - In RUNNING or LAP, when recordTimer ≥ LIMIT_RECORD_TIMER, the next posedge goes to PAUSED and sets overflow = 1.
  - This check has priority over button edges in the same cycle.
  - While overflow = 1, a startStop edge in PAUSED is ignored; only a lapReset edge (→ IDLE) clears the flag.
- Without the macro:
  - There is no limit check and overflow is tied to 0.
  - The count wraps naturally in the chronometer; LIMIT_RECORD_TIMER is unused.

Test Plan:
1. Reset, then a startStop pulse → enableTimmerCounter = 1 one clk later. Force recordTimer = 37, then a startStop pulse → PAUSED, enable = 0, displayValue = 37.
2. RUNNING with recordTimer = 120 at the lapReset edge → lapActive = 1 and displayValue stays 120 while recordTimer advances to 150. A second lapReset pulse → displayValue = 150, lapActive = 0.
3. PAUSED, then a lapReset pulse → resetChronometer = 1, state IDLE. A lapReset pulse in IDLE → no change.
4. Both buttons rise in the same cycle while RUNNING → PAUSED, no lap capture (lapTime keeps its prior value). Holding btnStartStop high for 10 cycles → only one transition.
5. With the macro defined, RUNNING and recordTimer = 511 → PAUSED and overflow = 1. A startStop pulse is ignored. A lapReset pulse → IDLE, overflow = 0. Without the macro, overflow stays 0 and running stays 1.
6. Assert reset asynchronously, mid-cycle, while in LAP → all outputs return to their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/stopwatch_controller_if.sv
// Stopwatch controller bundle: button levels and chronometer count in, chronometer
// control and display signals out. The controller uses the slave modport.
interface stopwatch_controller_if #(
   parameter int SIZE_RECORD_TIMER = 9
);
   logic                         btnStartStop;
   logic                         btnLapReset;
   logic [SIZE_RECORD_TIMER-1:0] recordTimer;
   logic                         resetChronometer;
   logic                         enableTimmerCounter;
   logic [SIZE_RECORD_TIMER-1:0] displayValue;
   logic                         lapActive;
   logic                         running;
   logic                         overflow;

   modport master (
      output btnStartStop, btnLapReset, recordTimer,
      input  resetChronometer, enableTimmerCounter, displayValue,
             lapActive, running, overflow
   );

   modport slave (
      input  btnStartStop, btnLapReset, recordTimer,
      output resetChronometer, enableTimmerCounter, displayValue,
             lapActive, running, overflow
   );
endinterface

// File: rtl/stopwatch_controller.sv
// Sequences one chronometer for a stopwatch: button edge detect, start/stop/lap FSM,
// lap freeze of the display. Define STOPWATCH_OVERFLOW_STOP_EN to stop and flag at the limit.
//
// state   | meaning
// IDLE    | chronometer held in clear, waiting for start
// RUNNING | counting, live value displayed
// LAP     | counting, display frozen at captured lap value
// PAUSED  | count held, live (held) value displayed
module stopwatch_controller #(
   parameter int SIZE_RECORD_TIMER  = 9,
   parameter int LIMIT_RECORD_TIMER = 511
) (
   input logic                  clk,
   input logic                  reset,
   stopwatch_controller_if.slave sw
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      LAP     = 2'd2,
      PAUSED  = 2'd3
   } state_t;

   if (LIMIT_RECORD_TIMER > (2 ** SIZE_RECORD_TIMER) - 1) begin : gLimitCheck
      $error("LIMIT_RECORD_TIMER does not fit in SIZE_RECORD_TIMER bits");
   end

   state_t                       state;
   state_t                       nextState;
   logic                         prevStartStop;
   logic                         prevLapReset;
   logic                         startEdge;
   logic                         lapEdge;
   logic [SIZE_RECORD_TIMER-1:0] lapTime;
   logic                         overflowQ;
   logic                         overflowTrip;

   assign startEdge = sw.btnStartStop & ~prevStartStop;
   assign lapEdge   = sw.btnLapReset  & ~prevLapReset;

`ifdef STOPWATCH_OVERFLOW_STOP_EN
   localparam logic [SIZE_RECORD_TIMER-1:0] LIMIT_VALUE =
      LIMIT_RECORD_TIMER[SIZE_RECORD_TIMER-1:0];

   assign overflowTrip = ((state == RUNNING) || (state == LAP)) &&
                         (sw.recordTimer >= LIMIT_VALUE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflowQ <= 1'b0;
      end else if (overflowTrip) begin
         overflowQ <= 1'b1;
      end else if (nextState == IDLE) begin
         overflowQ <= 1'b0;
      end
   end
`else
   assign overflowTrip = 1'b0;
   assign overflowQ    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prevStartStop <= 1'b0;
         prevLapReset  <= 1'b0;
         lapTime       <= '0;
      end else begin
         prevStartStop <= sw.btnStartStop;
         prevLapReset  <= sw.btnLapReset;
         if ((state == RUNNING) && (nextState == LAP)) begin
            lapTime <= sw.recordTimer;
         end
      end
   end

   // A start/stop edge always masks a lap/reset edge seen in the same cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (startEdge) nextState = RUNNING;
         end
         RUNNING: begin
            if (startEdge)    nextState = PAUSED;
            else if (lapEdge) nextState = LAP;
         end
         LAP: begin
            if (startEdge)    nextState = PAUSED;
            else if (lapEdge) nextState = RUNNING;
         end
         PAUSED: begin
            if (startEdge) begin
               if (!overflowQ) nextState = RUNNING;
            end else if (lapEdge) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      if (overflowTrip) nextState = PAUSED;
   end

   always_comb begin
      sw.resetChronometer    = 1'b0;
      sw.enableTimmerCounter = 1'b0;
      sw.running             = 1'b0;
      sw.lapActive           = 1'b0;
      sw.overflow            = overflowQ;
      sw.displayValue        = sw.recordTimer;
      case (state)
         IDLE: sw.resetChronometer = 1'b1;
         RUNNING: begin
            sw.enableTimmerCounter = 1'b1;
            sw.running             = 1'b1;
         end
         LAP: begin
            sw.enableTimmerCounter = 1'b1;
            sw.running             = 1'b1;
            sw.lapActive           = 1'b1;
            sw.displayValue        = lapTime;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller; follows STOPWATCH_OVERFLOW_STOP_EN for the limit case.
module tb_stopwatch_controller;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   stopwatch_controller_if #(.SIZE_RECORD_TIMER(9)) swIf ();

   stopwatch_controller #(
      .SIZE_RECORD_TIMER (9),
      .LIMIT_RECORD_TIMER(511)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sw   (swIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse one button for a single cycle; returns at the negedge after the sampling posedge.
   task automatic pressStart();
      @(negedge clk);
      swIf.btnStartStop = 1'b1;
      @(negedge clk);
      swIf.btnStartStop = 1'b0;
   endtask

   task automatic pressLap();
      @(negedge clk);
      swIf.btnLapReset = 1'b1;
      @(negedge clk);
      swIf.btnLapReset = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      swIf.btnStartStop = 1'b0;
      swIf.btnLapReset  = 1'b0;
      swIf.recordTimer  = 9'd5;
      repeat (3) @(negedge clk);

      chk("rst_resetChron", 32'(swIf.resetChronometer), 32'd1);
      chk("rst_enable",     32'(swIf.enableTimmerCounter), 32'd0);
      chk("rst_running",    32'(swIf.running), 32'd0);
      chk("rst_lapActive",  32'(swIf.lapActive), 32'd0);
      chk("rst_overflow",   32'(swIf.overflow), 32'd0);
      chk("rst_display",    32'(swIf.displayValue), 32'd5);
      reset = 1'b0;
      @(negedge clk);

      // start, then stop at 37
      swIf.recordTimer = 9'd0;
      pressStart();
      chk("start_enable",      32'(swIf.enableTimmerCounter), 32'd1);
      chk("start_running",     32'(swIf.running), 32'd1);
      chk("start_resetChron",  32'(swIf.resetChronometer), 32'd0);
      swIf.recordTimer = 9'd37;
      pressStart();
      chk("stop_enable",  32'(swIf.enableTimmerCounter), 32'd0);
      chk("stop_display", 32'(swIf.displayValue), 32'd37);

      // lap freeze at 120 while count moves to 150
      pressStart();
      chk("resume_running", 32'(swIf.running), 32'd1);
      swIf.recordTimer = 9'd120;
      pressLap();
      chk("lap_active",  32'(swIf.lapActive), 32'd1);
      chk("lap_display", 32'(swIf.displayValue), 32'd120);
      swIf.recordTimer = 9'd150;
      @(negedge clk);
      chk("lap_frozen",  32'(swIf.displayValue), 32'd120);
      chk("lap_enable",  32'(swIf.enableTimmerCounter), 32'd1);
      pressLap();
      chk("unlap_display", 32'(swIf.displayValue), 32'd150);
      chk("unlap_active",  32'(swIf.lapActive), 32'd0);
      chk("unlap_running", 32'(swIf.running), 32'd1);

      // simultaneous edges: start/stop wins
      swIf.recordTimer = 9'd200;
      @(negedge clk);
      swIf.btnStartStop = 1'b1;
      swIf.btnLapReset  = 1'b1;
      @(negedge clk);
      swIf.btnStartStop = 1'b0;
      swIf.btnLapReset  = 1'b0;
      chk("both_running",   32'(swIf.running), 32'd0);
      chk("both_lapActive", 32'(swIf.lapActive), 32'd0);
      chk("both_display",   32'(swIf.displayValue), 32'd200);
      chk("both_resetChron", 32'(swIf.resetChronometer), 32'd0);

      // holding start/stop for 10 cycles gives one transition
      pressStart();
      chk("hold_pre_running", 32'(swIf.running), 32'd1);
      @(negedge clk);
      swIf.btnStartStop = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold_running", 32'(swIf.running), 32'd0);
      swIf.btnStartStop = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_release_running", 32'(swIf.running), 32'd0);

      // PAUSED + lap/reset clears; lap/reset in IDLE does nothing
      pressLap();
      chk("clear_resetChron", 32'(swIf.resetChronometer), 32'd1);
      chk("clear_running",    32'(swIf.running), 32'd0);
      pressLap();
      chk("idle_lap_resetChron", 32'(swIf.resetChronometer), 32'd1);
      chk("idle_lap_running",    32'(swIf.running), 32'd0);
      chk("idle_lap_active",     32'(swIf.lapActive), 32'd0);

      // limit behaviour
      swIf.recordTimer = 9'd10;
      pressStart();
      chk("lim_start_running", 32'(swIf.running), 32'd1);
      swIf.recordTimer = 9'd511;
      @(negedge clk);
`ifdef STOPWATCH_OVERFLOW_STOP_EN
      chk("ovf_running", 32'(swIf.running), 32'd0);
      chk("ovf_flag",    32'(swIf.overflow), 32'd1);
      pressStart();
      chk("ovf_start_ignored", 32'(swIf.running), 32'd0);
      chk("ovf_flag_held",     32'(swIf.overflow), 32'd1);
      pressLap();
      chk("ovf_clear_resetChron", 32'(swIf.resetChronometer), 32'd1);
      chk("ovf_clear_flag",       32'(swIf.overflow), 32'd0);
      swIf.recordTimer = 9'd50;
      pressStart();
`else
      repeat (3) @(negedge clk);
      chk("noovf_running", 32'(swIf.running), 32'd1);
      chk("noovf_flag",    32'(swIf.overflow), 32'd0);
      swIf.recordTimer = 9'd50;
      @(negedge clk);
`endif
      chk("pre_lap_running", 32'(swIf.running), 32'd1);

      // async reset mid-cycle while in LAP
      pressLap();
      chk("lap2_active",  32'(swIf.lapActive), 32'd1);
      chk("lap2_display", 32'(swIf.displayValue), 32'd50);
      swIf.recordTimer = 9'd60;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_resetChron", 32'(swIf.resetChronometer), 32'd1);
      chk("arst_enable",     32'(swIf.enableTimmerCounter), 32'd0);
      chk("arst_running",    32'(swIf.running), 32'd0);
      chk("arst_lapActive",  32'(swIf.lapActive), 32'd0);
      chk("arst_overflow",   32'(swIf.overflow), 32'd0);
      chk("arst_display",    32'(swIf.displayValue), 32'd60);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_resetChron", 32'(swIf.resetChronometer), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
